// File: rtl/ber_sync_ctrl_if.sv
// Bus bundle between the BER sync controller and its surroundings:
// received symbols and comparator strobes in, slot sequencing and
// measurement results out.
interface ber_sync_ctrl_if;
  logic [1:0]  bit_rev;
  logic        err_bit;
  logic        bit_tick;
  logic [1:0]  enable;
  logic [11:0] count;
  logic        lock;
  logic [10:0] count_frame;
  logic [19:0] error_cnt_display;
  logic        meas_done;

  // Environment side: drives symbols and error strobes, observes results.
  modport master (
    output bit_rev,
    output err_bit,
    input  bit_tick,
    input  enable,
    input  count,
    input  lock,
    input  count_frame,
    input  error_cnt_display,
    input  meas_done
  );

  // Controller side.
  modport slave (
    input  bit_rev,
    input  err_bit,
    output bit_tick,
    output enable,
    output count,
    output lock,
    output count_frame,
    output error_cnt_display,
    output meas_done
  );
endinterface

// File: rtl/ber_sync_ctrl.sv
// Frame synchroniser and BER accumulator for the QPSK bit-error test chain.
// Hunts for the Barker-13 sync word, qualifies lock over CONFIRM further
// frame ends, sequences the slot index for the m-sequence comparator and
// totals comparator error strobes over MEAS_FRAMES locked frames.
// ACC_SAT is the accumulator ceiling; it defaults to the full 20-bit range.
module ber_sync_ctrl #(
  parameter int          FRAME_LEN   = 1040,
  parameter logic [12:0] SYNC_WORD   = 13'b1111100110101,
  parameter int          CONFIRM     = 2,
  parameter int          MISS_MAX    = 3,
  parameter int          MEAS_FRAMES = 999,
  parameter logic [19:0] ACC_SAT     = 20'hFFFFF
) (
  input  logic           clk_fs,
  input  logic           rst_n,
  ber_sync_ctrl_if.slave bus
);

  localparam logic [11:0] FRAME_END    = 12'(FRAME_LEN - 1);
  localparam logic [11:0] PAYLOAD_LAST = 12'(FRAME_LEN - 14);
  localparam logic [3:0]  CONFIRM_N    = 4'(CONFIRM);
  localparam logic [3:0]  MISS_N       = 4'(MISS_MAX);
  localparam logic [10:0] MEAS_N       = 11'(MEAS_FRAMES);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCK   = 2'd2
  } state_t;

  state_t      state;
  logic        tick;
  logic [12:0] sr;
  logic [11:0] sc;
  logic [3:0]  hits;
  logic [3:0]  misses;
  logic [19:0] acc;
  logic [10:0] frames;
  logic [1:0]  enable;
  logic        lock;
  logic [19:0] display;
  logic        meas_done;

  logic [12:0] shifted;
  logic        match;
  logic        frame_end;
  logic        payload;
  logic [10:0] frames_next;
  logic        window_done;
  logic        hit_confirm;
  logic        miss_drop;
  logic [19:0] acc_next;

  // Slot-level decode: shifted sync window, frame position and counter lookahead.
  always_comb begin
    shifted     = {sr[11:0], (bus.bit_rev == 2'b11)};
    match       = (shifted == SYNC_WORD);
    frame_end   = (sc == FRAME_END);
    payload     = (sc <= PAYLOAD_LAST);
    frames_next = frames + 11'd1;
    window_done = (frames_next == MEAS_N);
    hit_confirm = ((hits + 4'd1) == CONFIRM_N);
    miss_drop   = ((misses + 4'd1) == MISS_N);
    if (acc >= ACC_SAT) begin
      acc_next = ACC_SAT;
    end else begin
      acc_next = acc + 20'd1;
    end
  end

  // Sync FSM, slot counter, error accumulator and measurement window.
  always_ff @(posedge clk_fs) begin
    if (!rst_n) begin
      state     <= SEARCH;
      tick      <= 1'b0;
      sr        <= 13'd0;
      sc        <= 12'd0;
      hits      <= 4'd0;
      misses    <= 4'd0;
      acc       <= 20'd0;
      frames    <= 11'd0;
      enable    <= 2'b00;
      lock      <= 1'b0;
      display   <= 20'd0;
      meas_done <= 1'b0;
    end else begin
      tick      <= ~tick;
      meas_done <= 1'b0;
      if (tick) begin
        sr <= shifted;
        case (state)
          SEARCH: begin
            sc <= 12'd0;
            if (match) begin
              state <= VERIFY;
              hits  <= 4'd0;
            end
          end

          VERIFY: begin
            if (frame_end) begin
              sc <= 12'd0;
              if (match) begin
                hits <= hits + 4'd1;
                if (hit_confirm) begin
                  state  <= LOCK;
                  lock   <= 1'b1;
                  enable <= 2'b01;
                  misses <= 4'd0;
                  acc    <= 20'd0;
                  frames <= 11'd0;
                end
              end else begin
                state <= SEARCH;
              end
            end else begin
              sc <= sc + 12'd1;
            end
          end

          LOCK: begin
            if (payload && bus.err_bit) begin
              acc <= acc_next;
            end
            if (frame_end) begin
              sc <= 12'd0;
              if (!match && miss_drop) begin
                // Losing lock abandons the window in flight; the display keeps
                // the last completed total.
                state  <= SEARCH;
                lock   <= 1'b0;
                enable <= 2'b00;
                misses <= 4'd0;
                acc    <= 20'd0;
                frames <= 11'd0;
              end else begin
                misses <= match ? 4'd0 : (misses + 4'd1);
                if (window_done) begin
                  display   <= acc;
                  meas_done <= 1'b1;
                  acc       <= 20'd0;
                  frames    <= 11'd0;
                end else begin
                  frames <= frames_next;
                end
              end
            end else begin
              sc <= sc + 12'd1;
            end
          end

          default: begin
            state  <= SEARCH;
            sc     <= 12'd0;
            lock   <= 1'b0;
            enable <= 2'b00;
          end
        endcase
      end
    end
  end

  assign bus.bit_tick          = tick;
  assign bus.enable            = enable;
  assign bus.count             = sc;
  assign bus.lock              = lock;
  assign bus.count_frame       = frames;
  assign bus.error_cnt_display = display;
  assign bus.meas_done         = meas_done;

endmodule
